// File: rtl/sparse_pkg.sv
// Shared types, FSM encoding and saturating adder for the N:M structured-sparse MAC PE.
package sparse_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int SPARSE_M   = 4;
  localparam int SPARSE_N   = 2;
  localparam int ACC_WIDTH  = 24;
  localparam int IDX_WIDTH  = $clog2(SPARSE_M);

  typedef logic        [SPARSE_N*DATA_WIDTH-1:0] wvec_t;
  typedef logic        [SPARSE_N*IDX_WIDTH-1:0]  idx_vec_t;
  typedef logic        [SPARSE_M*DATA_WIDTH-1:0] act_vec_t;
  typedef logic signed [ACC_WIDTH-1:0]           acc_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  // Adds two values and clamps to the signed range of a width-bit accumulator.
  // Callers pass sign-extended operands already inside that range.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 width = ACC_WIDTH
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (width - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (width - 1));
    if (s > hi) begin
      return hi[63:0];
    end
    if (s < lo) begin
      return lo[63:0];
    end
    return s[63:0];
  endfunction

endpackage

// File: rtl/sparse_lane_mult.sv
// One sparse lane: picks the activation addressed by its compressed index and
// multiplies it by the lane weight. Out-of-range indices select zero.
module sparse_lane_mult #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [M*DATA_WIDTH-1:0]     act_vec,
  input  logic [IDX_WIDTH-1:0]        idx,
  input  logic signed [DATA_WIDTH-1:0] w,
  output logic signed [2*DATA_WIDTH-1:0] prod
);
  import sparse_pkg::*;

  logic signed [DATA_WIDTH-1:0] act_sel;

  always_comb begin
    act_sel = '0;
    for (int k = 0; k < M; k++) begin
      if (idx == IDX_WIDTH'(k)) begin
        act_sel = act_vec[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign prod = (2*DATA_WIDTH)'(w) * (2*DATA_WIDTH)'(act_sel);

endmodule

// File: rtl/sparse_mac_pe.sv
// N:M structured-sparse MAC processing element: 3-stage pipeline (multiply, reduce,
// accumulate/output). Define SPARSE_MAC_SAT_EN for a saturating accumulator.
module sparse_mac_pe #(
  parameter int DATA_WIDTH = 8,
  parameter int M          = 4,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_WIDTH = (M > 1) ? $clog2(M) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [N*DATA_WIDTH-1:0]     w_val,
  input  logic [N*IDX_WIDTH-1:0]      w_idx,
  input  logic [M*DATA_WIDTH-1:0]     act_vec,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_psum,
  output logic [CNT_WIDTH-1:0]        out_groups
);
  import sparse_pkg::*;

  localparam int PW = 2*DATA_WIDTH;
  localparam int SW = 2*DATA_WIDTH + $clog2(N) + 1;

  if (N < 1 || N > M) begin : g_bad_n
    $error("sparse_mac_pe: N must satisfy 1 <= N <= M");
  end

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef SPARSE_MAC_SAT_EN
    logic signed [63:0] r;
    r = sat_add(64'(a), 64'(b), ACC_WIDTH);
    return r[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  logic stall;
  assign stall    = !en || (out_valid && !out_ready);
  assign in_ready = !stall;

  logic signed [PW-1:0] prod_c [N];

  for (genvar g = 0; g < N; g++) begin : g_lane
    sparse_lane_mult #(
      .DATA_WIDTH (DATA_WIDTH),
      .M          (M),
      .IDX_WIDTH  (IDX_WIDTH)
    ) u_lane (
      .act_vec (act_vec),
      .idx     (w_idx[g*IDX_WIDTH +: IDX_WIDTH]),
      .w       (w_val[g*DATA_WIDTH +: DATA_WIDTH]),
      .prod    (prod_c[g])
    );
  end

  // Stage 1: registered lane products
  logic                 vld_p1;
  logic                 last_p1;
  logic signed [PW-1:0] prod_p1 [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (!stall) begin
      vld_p1  <= in_valid;
      last_p1 <= in_last;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && in_valid) begin
      prod_p1 <= prod_c;
    end
  end

  // Stage 2: lane reduction
  logic                 vld_p2;
  logic                 last_p2;
  logic signed [SW-1:0] sum_c;
  logic signed [SW-1:0] sum_p2;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N; i++) begin
      sum_c = sum_c + SW'(prod_p1[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
    end else if (!stall) begin
      vld_p2  <= vld_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && vld_p1) begin
      sum_p2 <= sum_c;
    end
  end

  // Stage 3: accumulate and present result
  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum_ext;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        cnt_inc;

  assign sum_ext = ACC_WIDTH'(sum_p2);
  assign acc_nxt = acc_add(acc, sum_ext);
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACCUM;
      acc        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_psum   <= '0;
      out_groups <= '0;
    end else if (!stall) begin
      // Not stalled in OUT means the result was taken this cycle.
      unique case (state)
        ST_OUT: begin
          out_valid <= 1'b0;
          state     <= ST_ACCUM;
        end
        default: ;
      endcase
      if (vld_p2) begin
        if (last_p2) begin
          out_psum   <= acc_nxt;
          out_groups <= cnt_inc;
          out_valid  <= 1'b1;
          acc        <= '0;
          cnt        <= '0;
          state      <= ST_OUT;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_mac_pe.sv
// Directed bench for sparse_mac_pe: default, M=3 and ACC_WIDTH=17 instances.
module tb_sparse_mac_pe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic               in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [15:0]        w_val = '0;
  logic [3:0]         w_idx = '0;
  logic [31:0]        act_vec = '0;
  logic               out_valid, out_ready = 1'b1;
  logic signed [23:0] out_psum;
  logic [15:0]        out_groups;

  // M=3 instance
  logic               m3_valid = 1'b0, m3_last = 1'b0, m3_ready;
  logic [15:0]        m3_w = '0;
  logic [3:0]         m3_idx = '0;
  logic [23:0]        m3_act = '0;
  logic               m3_ov, m3_oready = 1'b1;
  logic signed [23:0] m3_psum;
  logic [15:0]        m3_groups;

  // ACC_WIDTH=17 instance
  logic               a17_valid = 1'b0, a17_last = 1'b0, a17_ready;
  logic [15:0]        a17_w = '0;
  logic [3:0]         a17_idx = '0;
  logic [31:0]        a17_act = '0;
  logic               a17_ov, a17_oready = 1'b1;
  logic signed [16:0] a17_psum;
  logic [15:0]        a17_groups;

  sparse_mac_pe dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .w_val(w_val), .w_idx(w_idx), .act_vec(act_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum), .out_groups(out_groups)
  );

  sparse_mac_pe #(.M(3)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(m3_valid), .in_ready(m3_ready),
    .in_last(m3_last), .w_val(m3_w), .w_idx(m3_idx), .act_vec(m3_act),
    .out_valid(m3_ov), .out_ready(m3_oready), .out_psum(m3_psum), .out_groups(m3_groups)
  );

  sparse_mac_pe #(.ACC_WIDTH(17)) dut_a17 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(a17_valid), .in_ready(a17_ready),
    .in_last(a17_last), .w_val(a17_w), .w_idx(a17_idx), .act_vec(a17_act),
    .out_valid(a17_ov), .out_ready(a17_oready), .out_psum(a17_psum), .out_groups(a17_groups)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] act;
    logic [15:0] w;
    logic [3:0]  idx;
    int          exp_psum;
  } vec_t;

  vec_t tbl [7];

  // Beat constants: act lanes 3..0, weight lanes 1..0, index lanes 1..0.
  localparam logic [31:0] ACT_17  = 32'h0705FE03;  // {7,5,-2,3}
  localparam logic [15:0] W_17    = 16'hFF04;      // {-1,4}
  localparam logic [3:0]  IDX_17  = 4'h2;          // {0,2}
  localparam logic [31:0] ACT_DUP = 32'h00008000;  // act[1] = -128
  localparam logic [15:0] W_DUP   = 16'h8080;      // {-128,-128}
  localparam logic [3:0]  IDX_DUP = 4'h5;          // {1,1}
  localparam logic [31:0] ACT_14  = 32'h0000FD0A;  // act[1]=-3, act[0]=10
  localparam logic [15:0] W_14    = 16'h0202;      // {2,2}
  localparam logic [3:0]  IDX_14  = 4'h4;          // {1,0} -> 20-6 = 14

  task automatic drive(input logic [31:0] a, input logic [15:0] w, input logic [3:0] ix, input logic last);
    act_vec  = a;
    w_val    = w;
    w_idx    = ix;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  // Called #1 after a clock edge; returns cycles from the accept edge to out_valid.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_single(input logic [31:0] a, input logic [15:0] w, input logic [3:0] ix,
                            input int exp_psum, input string nm);
    int n;
    drive(a, w, ix, 1'b1);
    #1;
    check({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(n);
    check({nm, "_latency"}, n, 3);
    check({nm, "_psum"}, out_psum, exp_psum);
    check({nm, "_groups"}, out_groups, 1);
    @(posedge clk); #1;
    check({nm, "_drain"}, out_valid, 0);
  endtask

  logic [3:0] m3_ix  [3] = '{4'hD, 4'hB, 4'hF};
  int         m3_exp [3] = '{24, 15, 0};

  initial begin
    int n;
    tbl[0] = '{ACT_17,       W_17,     IDX_17,  17};
    tbl[1] = '{ACT_DUP,      W_DUP,    IDX_DUP, 32768};
    tbl[2] = '{32'h01020304, 16'h807F, 4'hF,    -1};
    tbl[3] = '{ACT_17,       16'h03FB, 4'h9,    25};
    tbl[4] = '{ACT_17,       16'h0000, 4'h9,    0};
    tbl[5] = '{32'hFFFFFFFF, W_DUP,    4'hC,    256};
    tbl[6] = '{32'h7F000080, 16'h7F7F, 4'hC,    -127};

    // reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_psum", out_psum, 0);
    check("rst_groups", out_groups, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_single(tbl[i].act, tbl[i].w, tbl[i].idx, tbl[i].exp_psum, $sformatf("vec%0d", i));
    end

    // three back-to-back groups
    for (int g = 0; g < 3; g++) begin
      drive(ACT_14, W_14, IDX_14, (g == 2));
      #1;
      check($sformatf("b2b_in_ready%0d", g), in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(n);
    check("b2b_latency", n, 3);
    check("b2b_psum", out_psum, 42);
    check("b2b_groups", out_groups, 3);
    @(posedge clk); #1;

    // en low between two groups of one dot product
    drive(ACT_14, W_14, IDX_14, 1'b0);
    @(posedge clk); #1;
    en = 1'b0;
    drive(ACT_14, W_14, IDX_14, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
      check("en_in_ready", in_ready, 0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_out(n);
    check("en_psum", out_psum, 28);
    check("en_groups", out_groups, 2);
    @(posedge clk); #1;

    // backpressure: results 17 then 256, plus a third beat offered during the stall
    out_ready = 1'b0;
    drive(ACT_17, W_17, IDX_17, 1'b1);
    @(posedge clk); #1;
    drive(32'hFFFFFFFF, W_DUP, 4'hC, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_valid", out_valid, 1);
    check("bp_in_ready_drop", in_ready, 0);
    drive(ACT_DUP, W_DUP, IDX_DUP, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_psum%0d", c), out_psum, 17);
      check($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      check($sformatf("bp_hold_in_ready%0d", c), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_second_valid", out_valid, 1);
    check("bp_second_psum", out_psum, 256);
    check("bp_second_groups", out_groups, 1);
    @(posedge clk); #1;
    check("bp_gap", out_valid, 0);
    @(posedge clk); #1;
    check("bp_third_valid", out_valid, 1);
    check("bp_third_psum", out_psum, 32768);
    @(posedge clk); #1;

    // M=3: index 3 selects zero (act = {5,6,7}, w = {3,4})
    for (int i = 0; i < 3; i++) begin
      m3_act = 24'h050607;
      m3_w   = 16'h0304;
      m3_idx = m3_ix[i];
      m3_last = 1'b1;
      m3_valid = 1'b1;
      @(posedge clk); #1;
      m3_valid = 1'b0;
      n = 1;
      while (!m3_ov && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check($sformatf("m3_latency%0d", i), n, 3);
      check($sformatf("m3_psum%0d", i), m3_psum, m3_exp[i]);
      @(posedge clk); #1;
    end

    // ACC_WIDTH=17 overflow: 32768 + 32768
    a17_act = ACT_DUP;
    a17_w   = W_DUP;
    a17_idx = IDX_DUP;
    a17_last = 1'b0;
    a17_valid = 1'b1;
    @(posedge clk); #1;
    a17_last = 1'b1;
    @(posedge clk); #1;
    a17_valid = 1'b0;
    a17_last  = 1'b0;
    n = 1;
    while (!a17_ov && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
`ifdef SPARSE_MAC_SAT_EN
    check("a17_psum", a17_psum, 65535);
`else
    // 65536 wraps to -2^16 in a 17-bit signed accumulator
    check("a17_psum", a17_psum, -65536);
`endif
    check("a17_groups", a17_groups, 2);
    @(posedge clk); #1;

    // reset after two of four groups
    drive(ACT_14, W_14, IDX_14, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_psum", out_psum, 0);
    check("mid_rst_groups", out_groups, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_single(ACT_17, W_17, IDX_17, 17, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
